fir_decim_sequencer: RTL

- Control sequencer for a time-multiplexed FIR-plus-decimate datapath. It replaces a fully parallel FIR with one shared multiply-accumulate (MAC) unit.
- Owns the write pointer of the external sample ring RAM and the decimation phase.
- On every DECIM-th accepted sample, it walks NUM_TAPS sample/coefficient address pairs into the MAC, then flags the result.
- Sits between the single-sample input strobe and the external sample RAM, coefficient ROM and MAC.

---
 rtl/fir_decim_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fir_decim_sequencer.sv
// Sequencer for a time-multiplexed FIR + decimator: owns the sample ring write pointer and
// walks tap address pairs into a shared MAC. Optional macro: FIR_SEQ_SYMMETRIC_EN (folded taps).
module fir_decim_sequencer #(
  parameter int NUM_TAPS = 32,
  parameter int DECIM    = 4,
  parameter int DEPTH    = 64,
  parameter int MAC_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_single_valid_in,
  output logic                        o_wr_en,
  output logic [$clog2(DEPTH)-1:0]    o_wr_addr,
  output logic [$clog2(DEPTH)-1:0]    o_rd_addr,
`ifdef FIR_SEQ_SYMMETRIC_EN
  output logic [$clog2(DEPTH)-1:0]    o_rd_addr_b,
`endif
  output logic [$clog2(NUM_TAPS)-1:0] o_coef_addr,
  output logic                        o_mac_clear,
  output logic                        o_mac_en,
  output logic                        o_mac_last,
  output logic                        o_valid_out,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(NUM_TAPS);
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef FIR_SEQ_SYMMETRIC_EN
  localparam int RUN_LEN = NUM_TAPS / 2;
  localparam logic [AW-1:0] TAIL_OFS = AW'(NUM_TAPS - 1);
`else
  localparam int RUN_LEN = NUM_TAPS;
`endif
  localparam logic [CW-1:0]  K_LAST     = CW'(RUN_LEN - 1);
  localparam logic [DCW-1:0] D_LAST     = DCW'(DECIM - 1);
  localparam logic [2:0]     DRAIN_LAST = 3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [AW-1:0]  r_wrAddr;
  logic [AW-1:0]  r_newest;
  logic [DCW-1:0] r_dcnt;
  logic [CW-1:0]  r_k;
  logic [2:0]     r_drainCnt;
  logic           r_overrun;
  logic           w_trigger;

  assign w_trigger = i_single_valid_in && (r_dcnt == D_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wrAddr   <= '0;
      r_newest   <= '0;
      r_dcnt     <= '0;
      r_k        <= '0;
      r_drainCnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (i_single_valid_in) begin
        r_wrAddr <= r_wrAddr + AW'(1);
        r_dcnt   <= (r_dcnt == D_LAST) ? '0 : r_dcnt + DCW'(1);
      end
      // The tap index is left at its final value after RUN so read/coef addresses hold.
      if (w_trigger && (r_state == IDLE)) begin
        r_newest <= r_wrAddr;
        r_k      <= '0;
      end else if ((r_state == RUN) && (r_k != K_LAST)) begin
        r_k <= r_k + CW'(1);
      end
      if (r_state == RUN)
        r_drainCnt <= '0;
      else if (r_state == DRAIN)
        r_drainCnt <= r_drainCnt + 3'd1;
      if (w_trigger && (r_state != IDLE))
        r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_mac_en    = 1'b0;
    o_mac_clear = 1'b0;
    o_mac_last  = 1'b0;
    o_valid_out = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_trigger)
          w_nextState = RUN;
      end
      RUN: begin
        o_mac_en    = 1'b1;
        o_mac_clear = (r_k == '0);
        o_mac_last  = (r_k == K_LAST);
        if (r_k == K_LAST)
          w_nextState = (MAC_LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (r_drainCnt == DRAIN_LAST)
          w_nextState = DONE;
      end
      DONE: begin
        o_valid_out = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign o_wr_en     = i_single_valid_in;
  assign o_wr_addr   = r_wrAddr;
  assign o_rd_addr   = r_newest - AW'(r_k);
  assign o_coef_addr = r_k;
  assign o_overrun   = r_overrun;
`ifdef FIR_SEQ_SYMMETRIC_EN
  assign o_rd_addr_b = r_newest - TAIL_OFS + AW'(r_k);
`endif

endmodule
